// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN sideband definitions: message encodings and calibration FSM states.
package mbtrain_pkg;

    localparam logic [3:0] MSG_NONE       = 4'b0000;
    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        SEND_START_REQ  = 3'd1,
        WAIT_START_RESP = 3'd2,
        CAL_WAIT        = 3'd3,
        SEND_END_REQ    = 3'd4,
        WAIT_END_RESP   = 3'd5,
        TEST_FINISHED   = 3'd6,
        TIMED_OUT       = 3'd7
    } state_t;

endpackage

// File: rtl/sb_valid_ctrl.sv
// Sideband transmit-valid handshake: request flag, yield to partner valid,
// clear on serializer busy negedge, and falling-edge detect of the valid.
module sb_valid_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_set,
    input  logic valid_rx,
    input  logic busy_negedge,
    output logic valid,
    output logic valid_fall
);

    logic req;
    logic valid_q;

    // The request is consumed only when valid actually rises, so a busy
    // negedge colliding with the rise leaves it pending for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req     <= 1'b0;
            valid   <= 1'b0;
            valid_q <= 1'b0;
        end else if (!en) begin
            req     <= 1'b0;
            valid   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid;
            if (busy_negedge)
                valid <= 1'b0;
            else if (req && !valid_rx)
                valid <= 1'b1;
            if (req_set)
                req <= 1'b1;
            else if (req && !valid_rx && !busy_negedge)
                req <= 1'b0;
        end
    end

    assign valid_fall = valid_q & ~valid;

endmodule

// File: rtl/rx_cal_tx.sv
// MBTRAIN RXCLKCAL initiator: start/end request-response handshake around a fixed
// calibration window. Optional response timeout enabled by RX_CAL_TX_TIMEOUT_EN.
module rx_cal_tx
    import mbtrain_pkg::*;
#(
    parameter int CAL_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_sideband_valid,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_test_ack,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_CYCLES - 1);

    state_t           cs;
    logic [CNT_W-1:0] cnt;
    logic             resp_latched;
    logic             valid_fall;
    logic             req_set;
    logic             start_hit;
    logic             end_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign start_hit = i_sideband_valid && (i_decoded_sideband_message == MSG_START_RESP);
    assign end_hit   = i_sideband_valid && (i_decoded_sideband_message == MSG_END_RESP);

    // Raised on the same edge that enters a SEND state so the flag and state line up.
    assign req_set = i_en && ((cs == IDLE) || (cs == CAL_WAIT && cnt == CAL_LAST));

    sb_valid_ctrl u_valid_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (i_en),
        .req_set      (req_set),
        .valid_rx     (i_valid_rx),
        .busy_negedge (i_busy_negedge_detected),
        .valid        (o_valid_tx),
        .valid_fall   (valid_fall)
    );

`ifdef RX_CAL_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    // Dropping i_en only redirects the state; IDLE wipes the outputs one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs                 <= IDLE;
            o_sideband_message <= MSG_NONE;
            o_test_ack         <= 1'b0;
            cnt                <= '0;
            resp_latched       <= 1'b0;
`ifdef RX_CAL_TX_TIMEOUT_EN
            timeout_q          <= 1'b0;
`endif
        end else if (cs != IDLE && !i_en) begin
            cs <= IDLE;
        end else begin
            case (cs)
                IDLE: begin
                    o_sideband_message <= MSG_NONE;
                    o_test_ack         <= 1'b0;
                    cnt                <= '0;
                    resp_latched       <= 1'b0;
`ifdef RX_CAL_TX_TIMEOUT_EN
                    timeout_q          <= 1'b0;
`endif
                    if (i_en) begin
                        cs                 <= SEND_START_REQ;
                        o_sideband_message <= MSG_START_REQ;
                    end
                end
                SEND_START_REQ: begin
                    if (start_hit)
                        resp_latched <= 1'b1;
                    if (valid_fall) begin
                        cs  <= WAIT_START_RESP;
                        cnt <= '0;
                    end
                end
                WAIT_START_RESP: begin
                    resp_latched <= 1'b0;
                    if (resp_latched || start_hit) begin
                        cs  <= CAL_WAIT;
                        cnt <= '0;
                    end
`ifdef RX_CAL_TX_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        cs        <= TIMED_OUT;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
`endif
                end
                CAL_WAIT: begin
                    if (cnt == CAL_LAST) begin
                        cs                 <= SEND_END_REQ;
                        o_sideband_message <= MSG_END_REQ;
                        cnt                <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                SEND_END_REQ: begin
                    if (end_hit)
                        resp_latched <= 1'b1;
                    if (valid_fall) begin
                        cs  <= WAIT_END_RESP;
                        cnt <= '0;
                    end
                end
                WAIT_END_RESP: begin
                    resp_latched <= 1'b0;
                    if (resp_latched || end_hit) begin
                        cs                 <= TEST_FINISHED;
                        o_test_ack         <= 1'b1;
                        o_sideband_message <= MSG_NONE;
                    end
`ifdef RX_CAL_TX_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        cs        <= TIMED_OUT;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
`endif
                end
                TEST_FINISHED: begin
                    o_test_ack         <= 1'b1;
                    o_sideband_message <= MSG_NONE;
                end
                TIMED_OUT: begin
                    o_test_ack <= 1'b0;
`ifdef RX_CAL_TX_TIMEOUT_EN
                    timeout_q  <= 1'b1;
`endif
                end
                default: cs <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_cal_tx.sv
// Self-checking bench for rx_cal_tx: directed scenarios plus randomized handshakes
// checked cycle by cycle against an event-time model of the exchange.
module tb_rx_cal_tx;
    import mbtrain_pkg::*;

    localparam int CAL = 16;
    localparam int TO  = 20;
`ifdef RX_CAL_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic [3:0] i_decoded_sideband_message;
    logic       i_sideband_valid;
    logic       i_busy_negedge_detected;
    logic       i_valid_rx;
    logic [3:0] o_sideband_message;
    logic       o_valid_tx;
    logic       o_test_ack;
    logic       o_timeout;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    rx_cal_tx #(.CAL_CYCLES(CAL), .TIMEOUT_CYCLES(TO)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_sideband_valid           (i_sideband_valid),
        .i_busy_negedge_detected    (i_busy_negedge_detected),
        .i_valid_rx                 (i_valid_rx),
        .o_sideband_message         (o_sideband_message),
        .o_valid_tx                 (o_valid_tx),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    task automatic applyStimulus(input logic en, input logic vrx, input logic busy,
                                 input logic sbv, input logic [3:0] msg);
        i_en                       = en;
        i_valid_rx                 = vrx;
        i_busy_negedge_detected    = busy;
        i_sideband_valid           = sbv;
        i_decoded_sideband_message = msg;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int e, input logic [3:0] em,
                               input logic ev, input logic ea, input logic et);
        nChecks++;
        assert (o_sideband_message === em) nPass++;
        else $error("[TB] FAIL %s msg edge %0d: observed %b expected %b", tag, e, o_sideband_message, em);
        nChecks++;
        assert (o_valid_tx === ev) nPass++;
        else $error("[TB] FAIL %s valid edge %0d: observed %b expected %b", tag, e, o_valid_tx, ev);
        nChecks++;
        assert (o_test_ack === ea) nPass++;
        else $error("[TB] FAIL %s ack edge %0d: observed %b expected %b", tag, e, o_test_ack, ea);
        nChecks++;
        assert (o_timeout === et) nPass++;
        else $error("[TB] FAIL %s timeout edge %0d: observed %b expected %b", tag, e, o_timeout, et);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Edges are numbered from the run start; edge 1 is the first edge sampling i_en=1.
    // mode 0: full handshake, 1: stop while END_REQ valid is high,
    // 2: no START_RESP ever, 3: drop i_en in the calibration window.
    task automatic runHandshake(input string tag, input int y, input int d, input int s_off,
                                input int d2, input int s2_off, input bit collide, input int mode);
        int r0, r, b, s, c, w, r2, b2, s2, ee, a, last;
        logic en, vrx, busy, sbv, ev, ea, et;
        logic [3:0] m, em;
        r0 = 2 + y;
        r  = r0 + (collide ? 1 : 0);
        b  = r + d;
        w  = b + 1;
        s  = (mode == 2) ? 1000000 : b + s_off;
        c  = imax(s, b + 2);
        r2 = c + CAL + 1;
        b2 = r2 + d2;
        s2 = b2 + s2_off;
        ee = imax(s2, b2 + 2);
        a  = c + 5;
        case (mode)
            0:       last = ee + 2;
            1:       last = r2 + 1;
            2:       last = w + TO + 2;
            default: last = a + 2;
        endcase
        for (int e = 1; e <= last; e++) begin
            en   = !(mode == 3 && e >= a);
            vrx  = (e >= 2 && e <= y + 1);
            busy = (collide && e == r0) || (e == b) || (e == b2);
            sbv  = 1'b0;
            m    = 4'($urandom_range(0, 15));
            if (e == s) begin
                sbv = 1'b1;
                m   = MSG_START_RESP;
            end else if (e == s2) begin
                sbv = 1'b1;
                m   = MSG_END_RESP;
            end else begin
                if (m == MSG_START_RESP || m == MSG_END_RESP)
                    m = 4'hF;
                sbv = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(en, vrx, busy, sbv, m);
            ev = (e >= r && e < b) || (e >= r2 && e < b2);
            em = (e < c + CAL) ? MSG_START_REQ : (e < ee) ? MSG_END_REQ : MSG_NONE;
            ea = (e >= ee);
            et = TO_EN && (mode == 2) && (e >= w + TO);
            if (mode == 3 && e > a) begin
                em = MSG_NONE;
                ev = 1'b0;
                ea = 1'b0;
                et = 1'b0;
            end else if (mode == 3 && e == a) begin
                ev = 1'b0;
            end
            checkOutput(tag, e, em, ev, ea, et);
        end
    endtask

    task automatic endRun(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput(tag, 2, MSG_NONE, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n                      = 1'b0;
        i_en                       = 1'b0;
        i_decoded_sideband_message = 4'h0;
        i_sideband_valid           = 1'b0;
        i_busy_negedge_detected    = 1'b0;
        i_valid_rx                 = 1'b0;
        #1;
        checkOutput("reset", 0, MSG_NONE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
            checkOutput("idle", i, MSG_NONE, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] nominal handshake");
        runHandshake("nominal", 0, 5, 3, 5, 3, 1'b0, 0);
        endRun("nominal_end");

        $display("[TB] yield to partner valid");
        runHandshake("yield", 10, 3, 2, 2, 1, 1'b0, 0);
        endRun("yield_end");

        $display("[TB] early responses");
        runHandshake("early", 0, 4, 0, 3, 0, 1'b0, 0);
        endRun("early_end");

        $display("[TB] busy negedge colliding with valid rise");
        runHandshake("collide", 2, 2, 1, 4, 2, 1'b1, 0);
        endRun("collide_end");

        $display("[TB] missing start response");
        runHandshake("timeout", 0, 3, 0, 1, 0, 1'b0, 2);
        endRun("timeout_end");

        $display("[TB] abort in calibration window and restart");
        runHandshake("abort", 1, 2, 1, 1, 0, 1'b0, 3);
        runHandshake("restart", 0, 3, 2, 3, 2, 1'b0, 0);
        endRun("restart_end");

        $display("[TB] async reset during end request");
        runHandshake("pre_reset", 0, 4, 2, 4, 2, 1'b0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, MSG_NONE, 1'b0, 1'b0, 1'b0);
        i_en                    = 1'b0;
        i_valid_rx              = 1'b0;
        i_busy_negedge_detected = 1'b0;
        i_sideband_valid        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset", 1, MSG_NONE, 1'b0, 1'b0, 1'b0);
        runHandshake("after_reset", 0, 2, 1, 2, 1, 1'b0, 0);
        endRun("after_reset_end");

        $display("[TB] randomized handshakes");
        for (int k = 0; k < 8; k++) begin
            runHandshake("random", int'($urandom_range(0, 6)), int'($urandom_range(1, 6)),
                         int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
                         int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0);
            endRun("random_end");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
